// File: rtl/nibble_serial_sub64_if.sv
// Operand/result bundle for the nibble-serial 64-bit subtractor.
// V and its modport entries exist only when OVF_DETECT_EN is defined.
interface nibble_serial_sub64_if;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic        Bin;
    logic        busy;
    logic        done;
    logic [63:0] D;
    logic        Bout;
`ifdef OVF_DETECT_EN
    logic        V;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout, V
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout, V
    );
`else
    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout
    );
`endif
endinterface

// File: rtl/nibble_serial_sub64.sv
// 64-bit subtractor D = A - B - Bin using one 4-bit adder, one nibble per cycle (16 cycles).
// Optional signed-overflow output V is built only when OVF_DETECT_EN is defined.
module nibble_serial_sub64 (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_sub64_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [63:0] a_q, b_q, d_q;
    logic [3:0]  idx_q;
    logic        carry_q;
    logic        bout_q;
    logic        load, step, last;
    logic        busy, done;
    logic [5:0]  base;
    logic [3:0]  a_nib, b_nib;
    logic [4:0]  sum;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                busy = 1'b1;
                step = 1'b1;
                if (idx_q == 4'd15) state_d = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = StBusy;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Subtraction as A + ~B + carry; carry starts at ~Bin.
    always_comb begin
        base  = {idx_q, 2'b00};
        a_nib = a_q[base +: 4];
        b_nib = b_q[base +: 4];
        sum   = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};
        last  = (idx_q == 4'd15);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
        end else if (load) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            d_q     <= '0;
            idx_q   <= '0;
            carry_q <= ~bus.Bin;
            bout_q  <= 1'b0;
        end else if (step) begin
            d_q[base +: 4] <= sum[3:0];
            carry_q        <= sum[4];
            idx_q          <= idx_q + 4'd1;
            if (last) bout_q <= ~sum[4];
        end
    end

`ifdef OVF_DETECT_EN
    logic v_q;

    // sum[3] on the last nibble is the final D[63].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else if (load) begin
            v_q <= 1'b0;
        end else if (step && last) begin
            v_q <= (a_q[63] != b_q[63]) && (sum[3] != a_q[63]);
        end
    end

    assign bus.V = v_q;
`endif

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.D    = d_q;
    assign bus.Bout = bout_q;

endmodule

// File: tb/tb_nibble_serial_sub64.sv
// Self-checking bench for nibble_serial_sub64; expected results come from a 65-bit reference
// subtraction queued at launch and popped when done is seen.
module tb_nibble_serial_sub64;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    typedef struct {
        logic [63:0] d;
        logic        bout;
        logic        v;
    } exp_t;

    exp_t sbq[$];

    nibble_serial_sub64_if bus ();

    nibble_serial_sub64 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [63:0] a, input logic [63:0] b, input logic bin);
        logic [64:0] diff;
        exp_t        e;
        diff   = {1'b0, a} - {1'b0, b} - {64'd0, bin};
        e.d    = diff[63:0];
        e.bout = diff[64];
        e.v    = (a[63] != b[63]) && (diff[63] != a[63]);
        sbq.push_back(e);
    endtask

    // Called at a negedge; returns one negedge after the accepting edge with start low.
    task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic bin);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        push_exp(a, b, bin);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int   n;
        bit   seen;
        exp_t e;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.busy, bus.done, bus.D, bus.Bout} !== 67'd0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b D=%h Bout=%b, want all 0",
                     bus.busy, bus.done, bus.D, bus.Bout);
        end
`ifdef OVF_DETECT_EN
        tests++;
        if (bus.V !== 1'b0) begin
            fails++;
            $display("FAIL reset_v: got %b want 0", bus.V);
        end
`endif
        // Start presented together with reset release must be taken on the first edge.
        rst_n = 1'b1;
        launch(64'h10, 64'h1, 1'b0);
        wait_done(n, seen);
        tests++;
        if (!seen || n != 16) begin
            fails++;
            $display("FAIL first_latency: seen=%0b cycles=%0d want 17", seen, n + 1);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if ({bus.D, bus.Bout} !== {e.d, e.bout}) begin
                fails++;
                $display("FAIL first_result: D=%h Bout=%b want D=%h Bout=%b",
                         bus.D, bus.Bout, e.d, e.bout);
            end
`ifdef OVF_DETECT_EN
            tests++;
            if (bus.V !== e.v) begin
                fails++;
                $display("FAIL first_v: got %b want %b", bus.V, e.v);
            end
`endif
        end
    endtask

    task automatic test_vectors();
        logic [63:0] ta[7];
        logic [63:0] tb[7];
        logic        tbin[7];
        logic [63:0] hold;
        int          n;
        bit          seen;
        exp_t        e;
        ta[0] = 64'h0;                  tb[0] = 64'h1;                  tbin[0] = 1'b0;
        ta[1] = 64'h5;                  tb[1] = 64'h5;                  tbin[1] = 1'b1;
        ta[2] = 64'h8000_0000_0000_0000; tb[2] = 64'h1;                 tbin[2] = 1'b0;
        ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb[3] = 64'hFFFF_FFFF_FFFF_FFFF; tbin[3] = 1'b0;
        ta[4] = 64'hFFFF_FFFF_FFFF_FFFF; tb[4] = 64'h0;                  tbin[4] = 1'b1;
        ta[5] = {$urandom, $urandom};   tb[5] = {$urandom, $urandom};   tbin[5] = 1'b1;
        ta[6] = {$urandom, $urandom};   tb[6] = {$urandom, $urandom};   tbin[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            launch(ta[i], tb[i], tbin[i]);
            tests++;
            if (bus.busy !== 1'b1 || bus.D !== 64'd0) begin
                fails++;
                $display("FAIL vec%0d_busy_clear: busy=%b D=%h want busy=1 D=0",
                         i, bus.busy, bus.D);
            end
            wait_done(n, seen);
            tests++;
            if (!seen || n != 16) begin
                fails++;
                $display("FAIL vec%0d_latency: seen=%0b cycles=%0d want 17", i, seen, n + 1);
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                tests++;
                if ({bus.D, bus.Bout} !== {e.d, e.bout}) begin
                    fails++;
                    $display("FAIL vec%0d_result: D=%h Bout=%b want D=%h Bout=%b",
                             i, bus.D, bus.Bout, e.d, e.bout);
                end
`ifdef OVF_DETECT_EN
                tests++;
                if (bus.V !== e.v) begin
                    fails++;
                    $display("FAIL vec%0d_v: got %b want %b", i, bus.V, e.v);
                end
`endif
            end
            hold = bus.D;
            @(negedge clk);
            tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.D !== hold) begin
                fails++;
                $display("FAIL vec%0d_hold: done=%b busy=%b D=%h want 0 0 %h",
                         i, bus.done, bus.busy, bus.D, hold);
            end
        end
    endtask

    task automatic test_ignore_start();
        int   n;
        bit   seen;
        exp_t e;
        @(negedge clk);
        launch(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 64'hFFFF_0000_FFFF_0000;
        bus.B     = 64'h1111_1111_1111_1111;
        bus.Bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if (bus.D[63:20] !== 44'd0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL ignore_partial: D=%h busy=%b want D[63:20]=0 busy=1",
                     bus.D, bus.busy);
        end
        wait_done(n, seen);
        tests++;
        if (!seen || n != 11) begin
            fails++;
            $display("FAIL ignore_latency: seen=%0b cycles=%0d want 17", seen, n + 6);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if ({bus.D, bus.Bout} !== {e.d, e.bout}) begin
                fails++;
                $display("FAIL ignore_result: D=%h Bout=%b want D=%h Bout=%b",
                         bus.D, bus.Bout, e.d, e.bout);
            end
        end
    endtask

    task automatic test_reset_abort();
        int   n;
        bit   seen;
        exp_t e;
        @(negedge clk);
        launch(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.D, bus.Bout} !== 67'd0) begin
            fails++;
            $display("FAIL abort_outputs: busy=%b done=%b D=%h Bout=%b want all 0",
                     bus.busy, bus.done, bus.D, bus.Bout);
        end
`ifdef OVF_DETECT_EN
        tests++;
        if (bus.V !== 1'b0) begin
            fails++;
            $display("FAIL abort_v: got %b want 0", bus.V);
        end
`endif
        if (sbq.size() > 0) void'(sbq.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL abort_quiet: activity after reset release, want none");
        end
        @(negedge clk);
        launch(64'h0000_0001_0000_0000, 64'h1, 1'b1);
        wait_done(n, seen);
        tests++;
        if (!seen || n != 16) begin
            fails++;
            $display("FAIL abort_restart_latency: seen=%0b cycles=%0d want 17", seen, n + 1);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if ({bus.D, bus.Bout} !== {e.d, e.bout}) begin
                fails++;
                $display("FAIL abort_restart_result: D=%h Bout=%b want D=%h Bout=%b",
                         bus.D, bus.Bout, e.d, e.bout);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        bit   seen;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 64'hAAAA_AAAA_AAAA_AAAA;
        bus.B     = 64'h5555_5555_5555_5556;
        bus.Bin   = 1'b0;
        push_exp(bus.A, bus.B, bus.Bin);
        @(negedge clk);
        // Start stays high; these operands are taken when the first op reaches DONE.
        bus.A   = 64'h1;
        bus.B   = 64'h8000_0000_0000_0000;
        bus.Bin = 1'b1;
        push_exp(bus.A, bus.B, bus.Bin);
        wait_done(n, seen);
        tests++;
        if (!seen || n != 16) begin
            fails++;
            $display("FAIL b2b_first_latency: seen=%0b cycles=%0d want 17", seen, n + 1);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if ({bus.D, bus.Bout} !== {e.d, e.bout}) begin
                fails++;
                $display("FAIL b2b_first_result: D=%h Bout=%b want D=%h Bout=%b",
                         bus.D, bus.Bout, e.d, e.bout);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_restart: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        wait_done(n, seen);
        tests++;
        if (!seen || n != 16) begin
            fails++;
            $display("FAIL b2b_spacing: seen=%0b spacing=%0d want 17", seen, n + 1);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if ({bus.D, bus.Bout} !== {e.d, e.bout}) begin
                fails++;
                $display("FAIL b2b_second_result: D=%h Bout=%b want D=%h Bout=%b",
                         bus.D, bus.Bout, e.d, e.bout);
            end
`ifdef OVF_DETECT_EN
            tests++;
            if (bus.V !== e.v) begin
                fails++;
                $display("FAIL b2b_second_v: got %b want %b", bus.V, e.v);
            end
`endif
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
